// File: rtl/snr_gain_ctrl.sv
// -----------------------------------------------------------------------------
// snr_gain_ctrl
//   Gain-range controller between filter_bandpass and the phase-detector
//   multiplier. Picks an 8-bit window of the 35-bit signed filter result,
//   saturates it symmetrically to -127..+127 and, when auto-ranging is
//   compiled in, steps the range from windowed peak/clip statistics.
//   Three level-sensitive keys give manual override.
//
// Build option
//   SNR_AUTO_EN  defined   : auto-ranging FSM and statistics present.
//                undefined : keys only (key==111 acts as key[0]); auto_mode
//                            and range_change tied low; datapath unchanged.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-high
//   sample_en     one-cycle strobe, filter_out valid
//   key[2:0]      manual range keys (level, active-high)
//   filter_out    signed band-pass filter output (35 bit)
//   gain_sel      one-hot range: 001=[33:26], 010=[29:22], 100=[27:20]
//   data_out      signed saturated slice, -127..+127
//   data_valid    high the cycle after sample_en
//   auto_mode     1 while auto-ranging is active
//   range_change  one-cycle pulse on every automatic gain step
// -----------------------------------------------------------------------------
module snr_gain_ctrl
`ifdef SNR_AUTO_EN
#(
  parameter int unsigned WIN_LEN    = 1024,
  parameter int unsigned SETTLE_LEN = 256,
  parameter int unsigned HI_TH      = 100,
  parameter int unsigned LO_TH      = 24
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic [2:0]         key,
  input  logic signed [34:0] filter_out,
  output logic [2:0]         gain_sel,
  output logic signed [7:0]  data_out,
  output logic               data_valid,
  output logic               auto_mode,
  output logic               range_change
);

  localparam int unsigned IN_W  = 35;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned MAG_W = 7;

  // Right-shift for each range (LSB position of the selected slice)
  localparam int unsigned SH_G0 = 26;
  localparam int unsigned SH_G1 = 22;
  localparam int unsigned SH_G2 = 20;

  localparam logic [2:0] GAIN_0 = 3'b001;  // lowest gain
  localparam logic [2:0] GAIN_1 = 3'b010;
  localparam logic [2:0] GAIN_2 = 3'b100;  // highest gain

  localparam logic signed [IN_W-1:0]  SAT_MAX_W = IN_W'(127);
  localparam logic signed [IN_W-1:0]  SAT_MIN_W = -IN_W'(127);
  localparam logic signed [OUT_W-1:0] SAT_MAX   = OUT_W'(127);
  localparam logic signed [OUT_W-1:0] SAT_MIN   = -OUT_W'(127);

  // ---------------------------------------------------------------------------
  // Datapath: arithmetic shift by the current range, then symmetric clamp.
  // gain_sel is only updated by registers, so each sample sees a single gain.
  // ---------------------------------------------------------------------------
  logic signed [IN_W-1:0]  shifted;
  logic                    clip_hi;
  logic                    clip_lo;
  logic signed [OUT_W-1:0] sat_now;

  always_comb begin
    shifted = filter_out >>> SH_G0;
    case (gain_sel)
      GAIN_1:  shifted = filter_out >>> SH_G1;
      GAIN_2:  shifted = filter_out >>> SH_G2;
      default: shifted = filter_out >>> SH_G0;
    endcase
  end

  // -128 falls under clip_lo so the output range stays symmetric
  always_comb begin
    clip_hi = (shifted > SAT_MAX_W);
    clip_lo = (shifted < SAT_MIN_W);
    sat_now = shifted[OUT_W-1:0];
    if (clip_hi) begin
      sat_now = SAT_MAX;
    end else if (clip_lo) begin
      sat_now = SAT_MIN;
    end
  end

  // Output register, one cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= sample_en;
      if (sample_en) begin
        data_out <= sat_now;
      end
    end
  end

  // Gain requested by the keys; key[0] has priority over key[1] over key[2]
  logic [2:0] key_gain;

  always_comb begin
    key_gain = GAIN_2;
    if (key[0]) begin
      key_gain = GAIN_0;
    end else if (key[1]) begin
      key_gain = GAIN_1;
    end
  end

`ifdef SNR_AUTO_EN
  // ---------------------------------------------------------------------------
  // Auto-ranging
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_MEASURE,
    ST_DECIDE,
    ST_SETTLE,
    ST_MANUAL
  } state_t;

  localparam int unsigned CNT_MAX = (WIN_LEN > SETTLE_LEN) ? WIN_LEN : SETTLE_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [OUT_W-1:0] HI_LIM      = OUT_W'(HI_TH);
  localparam logic [OUT_W-1:0] LO_LIM      = OUT_W'(LO_TH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [MAG_W-1:0] peak;
  logic             clip_seen;

  logic             clip_now;
  logic [OUT_W-1:0] neg_sat;
  logic [MAG_W-1:0] mag_now;
  logic             step_down;
  logic             step_up;

  // |data| of the clamped sample always fits in 7 bits (max 127)
  always_comb begin
    clip_now = clip_hi | clip_lo;
    neg_sat  = -sat_now;
    mag_now  = sat_now[OUT_W-1] ? neg_sat[MAG_W-1:0] : sat_now[MAG_W-1:0];
  end

  // Strict comparisons: a peak equal to either threshold keeps the range
  always_comb begin
    step_down = (clip_seen || ({1'b0, peak} > HI_LIM)) && (gain_sel != GAIN_0);
    step_up   = ({1'b0, peak} < LO_LIM) && (gain_sel != GAIN_2);
  end

  // Range FSM with statistics; keys take precedence over any FSM action
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_MEASURE;
      cnt          <= '0;
      peak         <= '0;
      clip_seen    <= 1'b0;
      gain_sel     <= GAIN_0;
      auto_mode    <= 1'b1;
      range_change <= 1'b0;
    end else begin
      range_change <= 1'b0;
      if (key == 3'b111) begin
        // Restart auto-ranging with a fresh window at the current gain
        auto_mode <= 1'b1;
        state     <= ST_MEASURE;
        cnt       <= '0;
        peak      <= '0;
        clip_seen <= 1'b0;
      end else if (key != 3'b000) begin
        auto_mode <= 1'b0;
        state     <= ST_MANUAL;
        gain_sel  <= key_gain;
        cnt       <= '0;
        peak      <= '0;
        clip_seen <= 1'b0;
      end else begin
        case (state)
          ST_MEASURE: begin
            if (sample_en) begin
              cnt <= cnt + CNT_ONE;
              if (mag_now > peak) begin
                peak <= mag_now;
              end
              if (clip_now) begin
                clip_seen <= 1'b1;
              end
              if (cnt == WIN_LAST) begin
                state <= ST_DECIDE;
              end
            end
          end

          // Samples arriving here still reach data_out but are not counted
          ST_DECIDE: begin
            cnt       <= '0;
            peak      <= '0;
            clip_seen <= 1'b0;
            if (step_down) begin
              gain_sel     <= {1'b0, gain_sel[2:1]};
              range_change <= 1'b1;
              state        <= ST_SETTLE;
            end else if (step_up) begin
              gain_sel     <= {gain_sel[1:0], 1'b0};
              range_change <= 1'b1;
              state        <= ST_SETTLE;
            end else begin
              state <= ST_MEASURE;
            end
          end

          // Let the filter output settle at the new range
          ST_SETTLE: begin
            if (sample_en) begin
              if (cnt == SETTLE_LAST) begin
                cnt   <= '0;
                state <= ST_MEASURE;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end

          ST_MANUAL: begin
            state <= ST_MANUAL;
          end

          default: begin
            state <= ST_MEASURE;
          end
        endcase
      end
    end
  end

`else
  // ---------------------------------------------------------------------------
  // Manual-only build: keys alone move the range
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain_sel <= GAIN_0;
    end else if (key != 3'b000) begin
      gain_sel <= key_gain;
    end
  end

  assign auto_mode    = 1'b0;
  assign range_change = 1'b0;
`endif

endmodule

// File: tb/tb_snr_gain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snr_gain_ctrl
//   Directed self-checking bench for snr_gain_ctrl. With SNR_AUTO_EN defined
//   the DUT runs with a 16-sample window and 8-sample settle period.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snr_gain_ctrl;

  logic               clk        = 1'b0;
  logic               rst        = 1'b1;
  logic               sample_en  = 1'b0;
  logic [2:0]         key        = 3'b000;
  logic signed [34:0] filter_out = '0;

  logic [2:0]         gain_sel;
  logic signed [7:0]  data_out;
  logic               data_valid;
  logic               auto_mode;
  logic               range_change;

  int checks   = 0;
  int errors   = 0;
  int rc_count = 0;

  always #5 clk = ~clk;

`ifdef SNR_AUTO_EN
  localparam logic AUTO_RST = 1'b1;
  localparam int   RC_TOTAL = 5;

  snr_gain_ctrl #(
    .WIN_LEN    (16),
    .SETTLE_LEN (8),
    .HI_TH      (100),
    .LO_TH      (24)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .key          (key),
    .filter_out   (filter_out),
    .gain_sel     (gain_sel),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .auto_mode    (auto_mode),
    .range_change (range_change)
  );
`else
  localparam logic AUTO_RST = 1'b0;
  localparam int   RC_TOTAL = 0;

  snr_gain_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .key          (key),
    .filter_out   (filter_out),
    .gain_sel     (gain_sel),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .auto_mode    (auto_mode),
    .range_change (range_change)
  );
`endif

  // Count range_change pulses (sampled before the edge updates it)
  always @(posedge clk) begin
    if (range_change === 1'b1) rc_count++;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [34:0] scaled(input int v, input int sh);
    logic signed [34:0] t;
    t = 35'(v);
    return t <<< sh;
  endfunction

  // One sample strobe; returns at the negedge where data_out is valid
  task automatic send(input logic signed [34:0] v);
    @(negedge clk);
    filter_out = v;
    sample_en  = 1'b1;
    @(negedge clk);
    sample_en  = 1'b0;
  endtask

  task automatic send_n(input logic signed [34:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] k);
    @(negedge clk);
    key = k;
    @(negedge clk);
    key = 3'b000;
  endtask

  initial begin
    // --- reset with strobes toggling ---
    filter_out = scaled(50, 26);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_en = ~sample_en;
    end
    @(negedge clk);
    check("rst_gain", gain_sel, 3'b001);
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_auto", auto_mode, AUTO_RST);
    check("rst_rc", range_change, 0);
    sample_en = 1'b0;
    rst = 1'b0;

    // --- datapath and saturation at gain 001 ---
    send(scaled(5, 26));
    check("dp_5", data_out, 5);
    check("dp_valid", data_valid, 1);
    idle(1);
    check("dp_valid_drop", data_valid, 0);
    send(scaled(200, 26));   check("dp_pos_sat", data_out, 127);
    send(scaled(-200, 26));  check("dp_neg_sat", data_out, -127);
    send(scaled(-128, 26));  check("dp_m128", data_out, -127);
    send(scaled(127, 26));   check("dp_p127", data_out, 127);
    send(scaled(-127, 26));  check("dp_m127", data_out, -127);

`ifdef SNR_AUTO_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // small input: step up to 010 after 16 samples
    send(scaled(3, 26));
    check("win_first", data_out, 3);
    send_n(scaled(3, 26), 15);
    idle(1);
    check("up_gain", gain_sel, 3'b010);
    check("up_pulse", range_change, 1);
    idle(1);
    check("up_pulse_end", range_change, 0);
    send_n(scaled(3, 26), 8);
    send_n(scaled(3, 26), 16);
    idle(2);
    check("mid_gain_hold", gain_sel, 3'b010);
    check("mid_data", data_out, 48);
    check("mid_rc", rc_count, 1);

    // peak exactly HI_TH: no change
    send_n(scaled(100, 22), 16);
    idle(2);
    check("hi_eq_gain", gain_sel, 3'b010);
    check("hi_eq_rc", rc_count, 1);

    // clipping at 010: step down
    send(scaled(40, 26));
    check("clip_data", data_out, 127);
    send_n(scaled(40, 26), 15);
    idle(1);
    check("down_gain", gain_sel, 3'b001);
    check("down_pulse", range_change, 1);
    send_n(scaled(40, 26), 8);
    check("down_data", data_out, 40);

    // at lowest gain a large peak cannot step further
    send_n(scaled(101, 26), 16);
    idle(2);
    check("limit_gain", gain_sel, 3'b001);
    check("limit_rc", rc_count, 2);

    // peak exactly LO_TH: no change; one below steps up
    send_n(scaled(24, 26), 16);
    idle(2);
    check("lo_eq_gain", gain_sel, 3'b001);
    send_n(scaled(23, 26), 16);
    idle(1);
    check("lo_step_gain", gain_sel, 3'b010);
    check("lo_step_pulse", range_change, 1);

    // manual override during SETTLE
    press(3'b100);
    check("man_gain", gain_sel, 3'b100);
    check("man_auto", auto_mode, 0);
    send_n(scaled(1, 20), 48);
    check("man_data", data_out, 1);
    idle(2);
    check("man_hold", gain_sel, 3'b100);
    check("man_rc", rc_count, 3);
    press(3'b010);
    check("man_gain2", gain_sel, 3'b010);

    // 111 resumes auto with a fresh 16-sample window
    press(3'b111);
    check("resume_auto", auto_mode, 1);
    check("resume_gain", gain_sel, 3'b010);
    send_n(scaled(1, 22), 15);
    idle(2);
    check("win15_gain", gain_sel, 3'b010);
    check("win15_rc", rc_count, 3);
    send(scaled(1, 22));
    idle(1);
    check("win16_gain", gain_sel, 3'b100);
    check("win16_pulse", range_change, 1);
    send(scaled(1, 22));
    check("g2_data", data_out, 4);
    send_n(scaled(1, 22), 2);

    // reset in the middle of SETTLE
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_gain", gain_sel, 3'b001);
    check("mrst_data", data_out, 0);
    check("mrst_valid", data_valid, 0);
    check("mrst_auto", auto_mode, 1);
    check("mrst_rc", range_change, 0);
    @(negedge clk);
    rst = 1'b0;
    send_n(scaled(3, 26), 16);
    idle(1);
    check("post_rst_gain", gain_sel, 3'b010);
    check("post_rst_pulse", range_change, 1);
    idle(1);
`else
    // keys only: small input never moves the range
    send_n(scaled(1, 26), 80);
    check("tiny_data", data_out, 1);
    idle(2);
    check("tiny_gain", gain_sel, 3'b001);
    check("tiny_auto", auto_mode, 0);
    press(3'b010);
    check("key010_gain", gain_sel, 3'b010);
    send(scaled(3, 26));
    check("key010_data", data_out, 48);
`endif

    // key priority
    press(3'b110);
    check("k110_gain", gain_sel, 3'b010);
    check("k110_auto", auto_mode, 0);
    press(3'b011);
    check("k011_gain", gain_sel, 3'b001);
    press(3'b100);
    check("k100_gain", gain_sel, 3'b100);
    send(scaled(3, 26));
    check("k100_data", data_out, 127);
    send(scaled(-1, 20));
    check("k100_neg1", data_out, -1);
    press(3'b111);
`ifdef SNR_AUTO_EN
    check("k111_gain", gain_sel, 3'b100);
    check("k111_auto", auto_mode, 1);
`else
    check("k111_gain", gain_sel, 3'b001);
    check("k111_auto", auto_mode, 0);
`endif
    idle(2);
    check("rc_total", rc_count, RC_TOTAL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
